uart2axi_bridge: RTL and testbench

//  UART-to-AXI4-Lite master bridge. A host sends framed commands over 8N1 UART.
//  The bridge issues 32-bit AXI4-Lite single-beat writes/reads to a memory-mapped slave.

---
 rtl/uart2axi_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_uart2axi_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart2axi_bridge.sv
// rtl/uart2axi_bridge.sv - UART 8N1 command framer driving AXI4-Lite single-beat writes/reads
// Optional write-response byte on uart_tx enabled by defining UART2AXI_WR_ACK_EN.
module uart2axi_bridge #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam int BIT = CLK_HZ / BAUD;
    localparam int CW  = $clog2(BIT) + 1;
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ADDR  = 4'd1;
    localparam logic [3:0] S_WDATA = 4'd2;
    localparam logic [3:0] S_AWW   = 4'd3;
    localparam logic [3:0] S_BRESP = 4'd4;
`ifdef UART2AXI_WR_ACK_EN
    localparam logic [3:0] S_ACK   = 4'd5;
`endif
    localparam logic [3:0] S_AR    = 4'd6;
    localparam logic [3:0] S_R     = 4'd7;
    localparam logic [3:0] S_TX    = 4'd8;

    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [1:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_byte;
    logic          r_rx_full;
    logic          w_rx_take;

    logic [9:0]    r_tx_shift;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bits;
    logic          r_tx_busy;
    logic          w_tx_start;
    logic [7:0]    w_tx_byte;

    logic [3:0]    r_state;
    logic          r_is_wr;
    logic [5:0]    r_count;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic          r_tx_sent;
    logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic          w_unused;
`ifdef UART2AXI_WR_ACK_EN
    logic [1:0]    r_bresp;
`endif

    assign w_unused = &{1'b0, m_axi_rresp, m_axi_bresp};

    // Start is confirmed at half-bit; every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_full  <= 1'b0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (w_rx_take)
                r_rx_full <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_s3 && !r_rx_s2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s2) begin
                            r_rx_byte <= r_rx_shift;
                            r_rx_full <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_busy  <= 1'b0;
        end else if (w_tx_start) begin
            r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == BIT_M1) begin
                r_tx_cnt   <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
                if (r_tx_bits == 4'd9)
                    r_tx_busy <= 1'b0;
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    assign uart_tx = r_tx_shift[0];

    // Read-side states swallow incoming bytes so they cannot leak into the next command.
    assign w_rx_take = r_rx_full && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_WDATA ||
                                     r_state == S_AR || r_state == S_R || r_state == S_TX);

`ifdef UART2AXI_WR_ACK_EN
    assign w_tx_start = !r_tx_sent && !r_tx_busy && (r_state == S_TX || r_state == S_ACK);
    assign w_tx_byte  = (r_state == S_ACK) ? {6'b0, r_bresp} : r_data[7:0];
`else
    assign w_tx_start = !r_tx_sent && !r_tx_busy && (r_state == S_TX);
    assign w_tx_byte  = r_data[7:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_is_wr    <= 1'b0;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tx_sent  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
`ifdef UART2AXI_WR_ACK_EN
            r_bresp    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_rx_full && (r_rx_byte[7:6] == 2'b01 || r_rx_byte[7:6] == 2'b10)) begin
                        r_is_wr    <= (r_rx_byte[7:6] == 2'b01);
                        r_count    <= r_rx_byte[5:0];
                        r_byte_idx <= '0;
                        r_state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (r_rx_full) begin
                        r_addr     <= {r_rx_byte, r_addr[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            if (r_is_wr) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state   <= S_AR;
                                r_arvalid <= 1'b1;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (r_rx_full) begin
                        r_data     <= {r_rx_byte, r_data[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state   <= S_AWW;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end
                end
                S_AWW: begin
                    if (m_axi_awready)
                        r_awvalid <= 1'b0;
                    if (m_axi_wready)
                        r_wvalid <= 1'b0;
                    if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_BRESP;
                    end
                end
                S_BRESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_addr   <= r_addr + 32'd4;
`ifdef UART2AXI_WR_ACK_EN
                        r_bresp  <= m_axi_bresp;
                        r_state  <= S_ACK;
`else
                        if (r_count == 6'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count - 6'd1;
                            r_state <= S_WDATA;
                        end
`endif
                    end
                end
`ifdef UART2AXI_WR_ACK_EN
                S_ACK: begin
                    if (w_tx_start) begin
                        r_tx_sent <= 1'b1;
                    end else if (r_tx_sent && !r_tx_busy) begin
                        r_tx_sent <= 1'b0;
                        if (r_count == 6'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count - 6'd1;
                            r_state <= S_WDATA;
                        end
                    end
                end
`endif
                S_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (m_axi_rvalid) begin
                        r_rready   <= 1'b0;
                        r_data     <= m_axi_rdata;
                        r_byte_idx <= '0;
                        r_state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (w_tx_start) begin
                        r_tx_sent <= 1'b1;
                    end else if (r_tx_sent && !r_tx_busy) begin
                        r_tx_sent  <= 1'b0;
                        r_data     <= {8'h00, r_data[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_addr <= r_addr + 32'd4;
                            if (r_count == 6'd0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_count   <= r_count - 6'd1;
                                r_state   <= S_AR;
                                r_arvalid <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_uart2axi_bridge.sv
// tb/tb_uart2axi_bridge.sv - directed self-checking bench for uart2axi_bridge
`timescale 1ns/1ps
module tb_uart2axi_bridge;

    localparam int BITC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    uart2axi_bridge #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          aw_last_wait = 0, w_last_wait = 0;
    bit          aw_got = 0, w_got = 0, rd_pend = 0;
    logic [31:0] aw_a, w_d, aw_first, w_first, rd_a;
    int          stab_err = 0, bready_err = 0, wstrb_err = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$], ar_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [7:0]  mon_b;

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (m_axi_awready) begin
                m_axi_awready = 0; aw_got = 1; aw_cnt = 0;
            end else if (m_axi_awvalid && !aw_got) begin
                if (aw_cnt == 0) aw_first = m_axi_awaddr;
                else if (m_axi_awaddr !== aw_first) stab_err++;
                if (aw_cnt >= aw_delay) begin
                    m_axi_awready = 1; aw_a = m_axi_awaddr; aw_last_wait = aw_cnt;
                end
                aw_cnt++;
            end else if (aw_cnt > 0 && !aw_got) stab_err++;
            if (m_axi_wready) begin
                m_axi_wready = 0; w_got = 1; w_cnt = 0;
            end else if (m_axi_wvalid && !w_got) begin
                if (w_cnt == 0) w_first = m_axi_wdata;
                else if (m_axi_wdata !== w_first) stab_err++;
                if (m_axi_wstrb !== 4'hF) wstrb_err++;
                if (w_cnt >= w_delay) begin
                    m_axi_wready = 1; w_d = m_axi_wdata; w_last_wait = w_cnt;
                end
                w_cnt++;
            end else if (w_cnt > 0 && !w_got) stab_err++;
            if (m_axi_bvalid) begin
                m_axi_bvalid = 0;
            end else if (m_axi_bready) begin
                if (!(aw_got && w_got)) bready_err++;
                else begin
                    m_axi_bvalid = 1;
                    wr_addr_q.push_back(aw_a);
                    wr_data_q.push_back(w_d);
                    mem[aw_a] = w_d;
                    aw_got = 0; w_got = 0;
                end
            end
            if (m_axi_arready) begin
                m_axi_arready = 0; ar_cnt = 0; rd_pend = 1;
            end else if (m_axi_arvalid && !rd_pend) begin
                if (ar_cnt >= ar_delay) begin
                    m_axi_arready = 1; ar_q.push_back(m_axi_araddr); rd_a = m_axi_araddr;
                end
                ar_cnt++;
            end
            if (m_axi_rvalid) begin
                m_axi_rvalid = 0;
            end else if (m_axi_rready && rd_pend) begin
                m_axi_rvalid = 1;
                m_axi_rdata = mem.exists(rd_a) ? mem[rd_a] : 32'h0;
                rd_pend = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (uart_tx === 1'b0 && rst) begin
            repeat (BITC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(negedge clk);
                mon_b[i] = uart_tx;
            end
            repeat (BITC) @(negedge clk);
            tx_q.push_back(mon_b);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        uart_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BITC) @(negedge clk);
        uart_rx = 1'b1;
        repeat (stop_bit ? BITC : 2 * BITC) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 5000 && wr_addr_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 5000 && tx_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); ar_q.delete(); tx_q.delete();
    endtask

    logic [31:0] t1_w [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [7:0]  t2_b [12] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77,
                               8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_cmd(8'h42, 32'h44A00000);
        for (int i = 0; i < 3; i++) send_word(t1_w[i]);
        wait_wr(3);
        repeat (200) @(negedge clk);
        chk("t1_nwr", wr_addr_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), wr_addr_q[i], 32'h44A00000 + 32'(4 * i));
            chk($sformatf("t1_data%0d", i), wr_data_q[i], t1_w[i]);
        end
`ifdef UART2AXI_WR_ACK_EN
        chk("t1_ack_n", tx_q.size(), 3);
        chk("t1_ack0", tx_q[0], 8'h00);
`else
        chk("t1_no_tx", tx_q.size(), 0);
`endif
        clear_logs();

        send_cmd(8'h82, 32'h44A00000);
        wait_tx(12);
        chk("t2_nar", ar_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_araddr%0d", i), ar_q[i], 32'h44A00000 + 32'(4 * i));
        chk("t2_ntx", tx_q.size(), 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("t2_tx%0d", i), tx_q[i], t2_b[i]);
        clear_logs();

        send_byte(8'h00);
        send_byte(8'hC5);
        repeat (100) @(negedge clk);
        chk("t3_no_aw", wr_addr_q.size(), 0);
        chk("t3_no_ar", ar_q.size(), 0);
        send_cmd(8'h40, 32'h00000010);
        send_word(32'hDEADBEEF);
        wait_wr(1);
        chk("t3_nwr", wr_addr_q.size(), 1);
        chk("t3_addr", wr_addr_q[0], 32'h00000010);
        chk("t3_data", wr_data_q[0], 32'hDEADBEEF);
        repeat (200) @(negedge clk);
        clear_logs();

        send_cmd(8'h40, 32'hFFFFFFFC);
        send_word(32'hCAFEF00D);
        wait_wr(1);
        chk("t4_waddr", wr_addr_q[0], 32'hFFFFFFFC);
        repeat (200) @(negedge clk);
        tx_q.delete();
        send_cmd(8'h81, 32'hFFFFFFFC);
        wait_tx(8);
        chk("t4_nar", ar_q.size(), 2);
        chk("t4_ar0", ar_q[0], 32'hFFFFFFFC);
        chk("t4_ar1_wrap", ar_q[1], 32'h00000000);
        chk("t4_rd0", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'hCAFEF00D);
        chk("t4_rd1", {tx_q[7], tx_q[6], tx_q[5], tx_q[4]}, 32'h00000000);
        clear_logs();

        aw_delay = 20; w_delay = 5;
        send_cmd(8'h40, 32'h00000100);
        send_word(32'h12345678);
        wait_wr(1);
        repeat (200) @(negedge clk);
        chk("t5_nwr", wr_addr_q.size(), 1);
        chk("t5_addr", wr_addr_q[0], 32'h00000100);
        chk("t5_data", wr_data_q[0], 32'h12345678);
        chk("t5_aw_wait", aw_last_wait, 20);
        chk("t5_w_wait", w_last_wait, 5);
        aw_delay = 0; w_delay = 0;
        clear_logs();

        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h77, 1'b0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'hA5A5A5A5);
        wait_wr(1);
        chk("t6_nwr", wr_addr_q.size(), 1);
        chk("t6_addr", wr_addr_q[0], 32'h00000200);
        chk("t6_data", wr_data_q[0], 32'hA5A5A5A5);
        repeat (200) @(negedge clk);
        clear_logs();

        send_cmd(8'h81, 32'h44A00000);
        for (int i = 0; i < 2000 && uart_tx !== 1'b0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t7_tx_active", uart_tx, 0);
        #1 rst = 1'b0;
        #1;
        chk("t7_rst_tx", uart_tx, 1);
        chk("t7_rst_rready", m_axi_rready, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ar_delay = 1000; ar_cnt = 0;
        send_cmd(8'h80, 32'h44A00000);
        for (int i = 0; i < 200 && m_axi_arvalid !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t7_arvalid_up", m_axi_arvalid, 1);
        #1 rst = 1'b0;
        #1;
        chk("t7_rst_arvalid", m_axi_arvalid, 0);
        chk("t7_rst_tx2", uart_tx, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ar_delay = 0; ar_cnt = 0;
        repeat (10) @(negedge clk);

        chk("stable_valids", stab_err, 0);
        chk("bready_after_hs", bready_err, 0);
        chk("wstrb_all_f", wstrb_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
